// File: rtl/vga_scan_timing.sv
// vga_scan_timing: raster counters for the snake display path, with
// registered sync, blanking, coordinate and pixel-strobe outputs.
module vga_scan_timing #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [10:0] vga_xpos,
  output logic [9:0]  vga_ypos,
  output logic        pix_ce,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [3:0]  div_cnt;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        tick;
  logic        line_wrap;
  logic        frame_wrap;
  logic        fresh;

  logic        hs_n;
  logic        vs_n;
  logic        de;
  logic        origin;

  assign tick       = (div_cnt == DIV_LAST);
  assign line_wrap  = (h_cnt == H_LAST);
  assign frame_wrap = (v_cnt == V_LAST);

  // Pixel divider and raster counters; fresh marks that the counters
  // hold a new pixel position (always true right after reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      fresh   <= 1'b1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 4'd1;
      fresh   <= tick;
      if (tick) begin
        if (line_wrap) begin
          h_cnt <= '0;
          v_cnt <= frame_wrap ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 11'd1;
        end
      end
    end
  end

  // Combinational decode of the current raster position.
  always_comb begin
    hs_n   = 1'b1;
    vs_n   = 1'b1;
    de     = 1'b0;
    origin = 1'b0;
    if ((h_cnt >= HS_BEG) && (h_cnt <= HS_END)) begin
      hs_n = 1'b0;
    end
    if ((v_cnt >= VS_BEG) && (v_cnt <= VS_END)) begin
      vs_n = 1'b0;
    end
    de     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    origin = (h_cnt == 11'd0) && (v_cnt == 10'd0);
  end

  // Output register stage: every output lags the counters by one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_de      <= 1'b0;
      vga_xpos    <= '0;
      vga_ypos    <= '0;
      pix_ce      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_hs      <= hs_n;
      vga_vs      <= vs_n;
      vga_de      <= de;
      vga_xpos    <= de ? h_cnt : '0;
      vga_ypos    <= de ? v_cnt : '0;
      pix_ce      <= fresh;
      frame_start <= fresh && origin;
    end
  end

endmodule

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing: vector table on the default build, scoreboard
// against a closed-form raster model on two reduced builds.
module tb_vga_scan_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  logic        a_hs, a_vs, a_de, a_ce, a_fs;
  logic [10:0] a_x;
  logic [9:0]  a_y;
  logic        b_hs, b_vs, b_de, b_ce, b_fs;
  logic [10:0] b_x;
  logic [9:0]  b_y;
  logic        c_hs, c_vs, c_de, c_ce, c_fs;
  logic [10:0] c_x;
  logic [9:0]  c_y;

  vga_scan_timing #(.CLK_DIV(2)) u_a (
    .clk(clk), .rst(rst_a),
    .vga_hs(a_hs), .vga_vs(a_vs), .vga_de(a_de),
    .vga_xpos(a_x), .vga_ypos(a_y),
    .pix_ce(a_ce), .frame_start(a_fs)
  );

  // reduced geometry: 16 x 10 raster, 8 x 6 visible
  vga_scan_timing #(
    .CLK_DIV(1),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (
    .clk(clk), .rst(rst_b),
    .vga_hs(b_hs), .vga_vs(b_vs), .vga_de(b_de),
    .vga_xpos(b_x), .vga_ypos(b_y),
    .pix_ce(b_ce), .frame_start(b_fs)
  );

  vga_scan_timing #(
    .CLK_DIV(3),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_c (
    .clk(clk), .rst(rst_c),
    .vga_hs(c_hs), .vga_vs(c_vs), .vga_de(c_de),
    .vga_xpos(c_x), .vga_ypos(c_y),
    .pix_ce(c_ce), .frame_start(c_fs)
  );

  // {hs, vs, de, x[10:0], y[9:0], ce, fs}
  logic [25:0] act_a, act_b, act_c;
  assign act_a = {a_hs, a_vs, a_de, a_x, a_y, a_ce, a_fs};
  assign act_b = {b_hs, b_vs, b_de, b_x, b_y, b_ce, b_fs};
  assign act_c = {c_hs, c_vs, c_de, c_x, c_y, c_ce, c_fs};

  typedef struct {
    int          n;
    logic [25:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [25:0] sb_q[$];
  logic [25:0] hist[$];
  int          fs_q[$];
  int          errors = 0;
  int          checks = 0;
  int          vs_low, vs_fall, hs_low0, ce_low;

  function automatic logic [25:0] pk(input logic hs, input logic vs,
                                     input logic de, input int x,
                                     input int y, input logic ce,
                                     input logic fs);
    return {hs, vs, de, 11'(x), 10'(y), ce, fs};
  endfunction

  // Closed-form expectation for the reduced builds, n clks after release.
  function automatic logic [25:0] model(input int n, input int div);
    int p, x, y;
    logic de, hs, vs, ce, fs;
    p  = n / div;
    x  = p % 16;
    y  = (p / 16) % 10;
    de = (x < 8) && (y < 6);
    hs = !((x >= 10) && (x <= 12));
    vs = !((y >= 7) && (y <= 8));
    ce = (n % div) == 0;
    fs = ce && (x == 0) && (y == 0);
    return pk(hs, vs, de, de ? x : 0, de ? y : 0, ce, fs);
  endfunction

  task automatic chk(input string nm, input int n,
                     input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got hs=%b vs=%b de=%b x=%0d y=%0d ce=%b fs=%b want hs=%b vs=%b de=%b x=%0d y=%0d ce=%b fs=%b",
               nm, n, act[25], act[24], act[23], act[22:12], act[11:2],
               act[1], act[0], exp[25], exp[24], exp[23], exp[22:12],
               exp[11:2], exp[1], exp[0]);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic add_vec(input int n, input logic [25:0] exp);
    vec_t v;
    v.n   = n;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic run_sb(input int which, input int div,
                        input int ncyc, input string tag);
    logic [25:0] act, exp;
    fs_q.delete();
    hist.delete();
    vs_low  = 0;
    vs_fall = -1;
    hs_low0 = 0;
    ce_low  = 0;
    for (int n = 0; n < ncyc; n++) begin
      sb_q.push_back(model(n, div));
      @(negedge clk);
      act = (which == 1) ? act_b : act_c;
      exp = sb_q.pop_front();
      chk(tag, n, act, exp);
      hist.push_back(act);
      if (act[0]) fs_q.push_back(n);
      if (!act[1]) ce_low++;
      if ((n < 16 * div) && !act[25]) hs_low0++;
      if ((n < 160 * div) && !act[24]) begin
        vs_low++;
        if (vs_fall < 0) vs_fall = n;
      end
    end
  endtask

  function automatic int fs_period();
    return (fs_q.size() >= 2) ? fs_q[1] - fs_q[0] : -1;
  endfunction

  localparam logic [25:0] RST_V = {1'b1, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0};

  initial begin
    int ti, de_cnt, hs_fall, hs_low, found;
    logic prev_hs;

    add_vec(0,    pk(1, 1, 1,   0, 0, 1, 1));
    add_vec(1,    pk(1, 1, 1,   0, 0, 0, 0));
    add_vec(2,    pk(1, 1, 1,   1, 0, 1, 0));
    add_vec(3,    pk(1, 1, 1,   1, 0, 0, 0));
    add_vec(1278, pk(1, 1, 1, 639, 0, 1, 0));
    add_vec(1279, pk(1, 1, 1, 639, 0, 0, 0));
    add_vec(1280, pk(1, 1, 0,   0, 0, 1, 0));
    add_vec(1310, pk(1, 1, 0,   0, 0, 1, 0));
    add_vec(1311, pk(1, 1, 0,   0, 0, 0, 0));
    add_vec(1312, pk(0, 1, 0,   0, 0, 1, 0));
    add_vec(1502, pk(0, 1, 0,   0, 0, 1, 0));
    add_vec(1503, pk(0, 1, 0,   0, 0, 0, 0));
    add_vec(1504, pk(1, 1, 0,   0, 0, 1, 0));
    add_vec(1598, pk(1, 1, 0,   0, 0, 1, 0));
    add_vec(1600, pk(1, 1, 1,   0, 1, 1, 0));
    add_vec(1601, pk(1, 1, 1,   0, 1, 0, 0));
    add_vec(1602, pk(1, 1, 1,   1, 1, 1, 0));
    add_vec(3200, pk(1, 1, 1,   0, 2, 1, 0));

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_a", 0, act_a, RST_V);
    chk("reset_b", 0, act_b, RST_V);
    chk("reset_c", 0, act_c, RST_V);

    // default build: first two lines
    rst_a   = 1'b0;
    ti      = 0;
    de_cnt  = 0;
    hs_fall = -1;
    hs_low  = 0;
    prev_hs = 1'b1;
    for (int n = 0; n <= 3200; n++) begin
      @(negedge clk);
      if ((ti < tbl.size()) && (tbl[ti].n == n)) begin
        chk($sformatf("tbl_a[%0d]", ti), n, act_a, tbl[ti].exp);
        ti++;
      end
      if (n < 1600) begin
        if (a_de) de_cnt++;
        if (!a_hs) hs_low++;
        if (prev_hs && !a_hs && (hs_fall < 0)) hs_fall = n;
      end
      prev_hs = a_hs;
    end
    chk_int("a_de_clks", de_cnt, 1280);
    chk_int("a_hs_fall", hs_fall, 1312);
    chk_int("a_hs_low", hs_low, 192);
    chk_int("a_tbl_used", ti, tbl.size());
    rst_a = 1'b1;

    // reduced build, one clk per pixel
    rst_b = 1'b0;
    run_sb(1, 1, 340, "sb_b");
    chk_int("b_fs_count", fs_q.size(), 3);
    chk_int("b_frame_period", fs_period(), 160);
    chk_int("b_hs_low", hs_low0, 3);
    chk_int("b_vs_low", vs_low, 32);
    chk_int("b_vs_fall", vs_fall, 112);
    chk_int("b_ce_low", ce_low, 0);
    chk("b_last_vis", 87, hist[87], pk(1, 1, 1, 7, 5, 1, 0));
    chk("b_after_vis", 88, hist[88], pk(1, 1, 0, 0, 0, 1, 0));

    // reset during a horizontal sync pulse
    found = 0;
    for (int k = 0; (k < 64) && (found == 0); k++) begin
      @(negedge clk);
      if (!b_hs) found = 1;
    end
    chk_int("b_hs_seen", found, 1);
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_midrst", 0, act_b, RST_V);
    rst_b = 1'b0;
    run_sb(1, 1, 170, "sb_b_post");
    chk_int("b_post_fs0", (fs_q.size() > 0) ? fs_q[0] : -1, 0);
    chk_int("b_post_period", fs_period(), 160);

    // reduced build, three clks per pixel
    rst_c = 1'b0;
    run_sb(2, 3, 500, "sb_c");
    chk_int("c_fs_count", fs_q.size(), 2);
    chk_int("c_frame_period", fs_period(), 480);
    chk_int("c_hs_low", hs_low0, 9);
    chk_int("c_vs_low", vs_low, 96);
    chk_int("c_vs_fall", vs_fall, 336);
    chk_int("c_ce_low", ce_low, 333);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
